// File: rtl/ex_issue_seq_if.sv
// Issue / ALU / write-back bundle between decode, the ALU and the sequencer.
interface ex_issue_seq_if;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [9:0]  circuit_sel_i;
  logic [4:0]  destination_i;
  logic [4:0]  destination2_i;
  logic        flush_i;
  logic [9:0]  ex_circuit_sel_o;
  logic [4:0]  ex_destination_o;
  logic [4:0]  ex_destination2_o;
  logic [31:0] result_i;
  logic [31:0] result2_i;
  logic        wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        psw_we_o;
  logic        busy_o;

  // decode + ALU side
  modport master (
    output issue_valid_i, circuit_sel_i, destination_i, destination2_i,
           flush_i, result_i, result2_i,
    input  issue_ready_o, ex_circuit_sel_o, ex_destination_o, ex_destination2_o,
           wb_en_o, wb_addr_o, wb_data_o, psw_we_o, busy_o
  );

  // sequencer side
  modport slave (
    input  issue_valid_i, circuit_sel_i, destination_i, destination2_i,
           flush_i, result_i, result2_i,
    output issue_ready_o, ex_circuit_sel_o, ex_destination_o, ex_destination2_o,
           wb_en_o, wb_addr_o, wb_data_o, psw_we_o, busy_o
  );
endinterface

// File: rtl/ex_issue_seq.sv
// Execute-stage issue/write-back sequencer: holds one op on the ALU for its
// class latency, then commits one or two results through the single GR port.
module ex_issue_seq #(
  parameter int          ALU_LAT = 1,
  parameter int          MUL_LAT = 2,
  parameter int          DIV_LAT = 34,
  parameter logic [9:0]  NOP_SEL = 10'h200
) (
  input  logic         clk,
  input  logic         rst,
  ex_issue_seq_if.slave bus
);
  localparam int MAXL = (DIV_LAT > MUL_LAT) ? ((DIV_LAT > ALU_LAT) ? DIV_LAT : ALU_LAT)
                                            : ((MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT);
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {IDLE, EXEC, WB1, WB2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      sel_q, sel_d;
  logic [4:0]      dst_q, dst_d, dst2_q, dst2_d;
  logic            gr_q, gr_d, psw_q, psw_d, dual_q, dual_d;

  logic            dec_gr, dec_psw, dec_dual;
  logic [CW-1:0]   dec_cnt;
  logic            wb_en, psw_we;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;

  // Op class decode; first matching rule wins, counter preload is LAT-1.
  always_comb begin
    dec_gr   = 1'b0;
    dec_psw  = 1'b0;
    dec_dual = 1'b0;
    dec_cnt  = CW'(ALU_LAT - 1);
    if (bus.circuit_sel_i[5] && bus.circuit_sel_i[0]) begin        // MOV
      dec_gr = 1'b1;
    end else if (bus.circuit_sel_i[5]) begin                       // ADD family
      dec_gr = 1'b1; dec_psw = 1'b1;
    end else if (bus.circuit_sel_i == 10'd0) begin                 // CMP
      dec_psw = 1'b1;
    end else if (bus.circuit_sel_i == 10'd2 || bus.circuit_sel_i == 10'd3) begin  // AND/OR
      dec_gr = 1'b1; dec_psw = 1'b1;
    end else if (bus.circuit_sel_i[4:1] == 4'b0011) begin          // BSH/BSW
      dec_gr = 1'b1; dec_psw = 1'b1;
    end else if (bus.circuit_sel_i == 10'd8) begin                 // DIV
      dec_gr = 1'b1; dec_psw = 1'b1; dec_dual = 1'b1;
      dec_cnt = CW'(DIV_LAT - 1);
    end else if (bus.circuit_sel_i == 10'd16) begin                // HSH/HSW
      dec_gr = 1'b1; dec_psw = 1'b1;
    end else if (bus.circuit_sel_i == 10'd64) begin                // SAR
      dec_psw = 1'b1;
    end else if (bus.circuit_sel_i == 10'd128) begin               // MUL
      dec_gr = 1'b1; dec_dual = 1'b1;
      dec_cnt = CW'(MUL_LAT - 1);
    end else begin                                                 // NOP
      dec_cnt = '0;
    end
  end

  // Next-state: launch on accept, count down in EXEC, then one or two WB cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    dst_d   = dst_q;
    dst2_d  = dst2_q;
    gr_d    = gr_q;
    psw_d   = psw_q;
    dual_d  = dual_q;
    case (state_q)
      IDLE: if (bus.issue_valid_i) begin
        state_d = EXEC;
        cnt_d   = dec_cnt;
        sel_d   = bus.circuit_sel_i;
        dst_d   = bus.destination_i;
        dst2_d  = bus.destination2_i;
        gr_d    = dec_gr;
        psw_d   = dec_psw;
        dual_d  = dec_dual;
      end
      EXEC: begin
        if (bus.flush_i) begin
          state_d = IDLE;
          sel_d   = NOP_SEL;
        end else if (cnt_q == '0) begin
          state_d = WB1;
        end
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      WB1: begin
        // flush is ignored once commit has started
        if (dual_q) begin
          state_d = WB2;
        end else begin
          state_d = IDLE;
          sel_d   = NOP_SEL;
        end
      end
      WB2: begin
        state_d = IDLE;
        sel_d   = NOP_SEL;
      end
      default: begin
        state_d = IDLE;
        sel_d   = NOP_SEL;
      end
    endcase
  end

  // State and launched-op registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= NOP_SEL;
      dst_q   <= '0;
      dst2_q  <= '0;
      gr_q    <= 1'b0;
      psw_q   <= 1'b0;
      dual_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dst_q   <= dst_d;
      dst2_q  <= dst2_d;
      gr_q    <= gr_d;
      psw_q   <= psw_d;
      dual_q  <= dual_d;
    end
  end

  // Write-back port; r0 is never written.
  always_comb begin
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    psw_we  = 1'b0;
    case (state_q)
      WB1: begin
        wb_en   = gr_q && (dst_q != 5'd0);
        wb_addr = dst_q;
        wb_data = bus.result_i;
        psw_we  = psw_q;
      end
      WB2: begin
        wb_en   = (dst2_q != 5'd0);
        wb_addr = dst2_q;
        wb_data = bus.result2_i;
      end
      default: ;
    endcase
  end

  assign bus.issue_ready_o     = (state_q == IDLE);
  assign bus.busy_o            = (state_q != IDLE);
  assign bus.ex_circuit_sel_o  = sel_q;
  assign bus.ex_destination_o  = dst_q;
  assign bus.ex_destination2_o = dst2_q;
  assign bus.wb_en_o           = wb_en;
  assign bus.wb_addr_o         = wb_addr;
  assign bus.wb_data_o         = wb_data;
  assign bus.psw_we_o          = psw_we;
endmodule

// File: tb/tb_ex_issue_seq.sv
// Bench for ex_issue_seq: directed op table, multi-cycle corner sequences,
// then random traffic against a timeline model of the sequencer.
module tb_ex_issue_seq;
  localparam logic [9:0] NOP = 10'h200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_issue_seq_if bif ();

  ex_issue_seq #(.ALU_LAT(1), .MUL_LAT(2), .DIV_LAT(34), .NOP_SEL(10'h200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [9:0]  sel;
    logic [4:0]  d, d2;
    logic [31:0] r, r2;
    int          lat;
    bit          dual, wb1, psw, wb2;
  } vec_t;

  typedef struct {
    int lat;
    bit gr, psw, dual;
  } cls_t;

  // Class rules applied to an op code, used by the random model.
  function automatic cls_t classify(input logic [9:0] s);
    cls_t c;
    c = '{lat: 1, gr: 1'b0, psw: 1'b0, dual: 1'b0};
    if (s[5] && s[0])                      c.gr = 1;
    else if (s[5])                         begin c.gr = 1; c.psw = 1; end
    else if (s == 0)                       c.psw = 1;
    else if (s == 2 || s == 3)             begin c.gr = 1; c.psw = 1; end
    else if (s[4:1] == 4'b0011)            begin c.gr = 1; c.psw = 1; end
    else if (s == 8)                       begin c.lat = 34; c.gr = 1; c.psw = 1; c.dual = 1; end
    else if (s == 16)                      begin c.gr = 1; c.psw = 1; end
    else if (s == 64)                      c.psw = 1;
    else if (s == 128)                     begin c.lat = 2; c.gr = 1; c.dual = 1; end
    return c;
  endfunction

  task automatic drive(input bit v, input logic [9:0] s, input logic [4:0] d, input logic [4:0] d2,
                       input bit fl, input logic [31:0] r, input logic [31:0] r2);
    bif.issue_valid_i  = v;
    bif.circuit_sel_i  = s;
    bif.destination_i  = d;
    bif.destination2_i = d2;
    bif.flush_i        = fl;
    bif.result_i       = r;
    bif.result2_i      = r2;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ready"}, bif.issue_ready_o, 1);
    chk({nm, "_busy"},  bif.busy_o, 0);
    chk({nm, "_sel"},   bif.ex_circuit_sel_o, NOP);
    chk({nm, "_wben"},  bif.wb_en_o, 0);
    chk({nm, "_pswwe"}, bif.psw_we_o, 0);
  endtask

  // Issue one op and follow it through EXEC, WB1, optional WB2, back to IDLE.
  task automatic run_op(input vec_t v, input string nm);
    @(negedge clk); drive(1, v.sel, v.d, v.d2, 0, v.r, v.r2); #1;
    chk({nm, "_acc_ready"}, bif.issue_ready_o, 1);
    for (int i = 1; i <= v.lat; i++) begin
      @(negedge clk); bif.issue_valid_i = 0; #1;
      chk({nm, "_ex_ready"}, bif.issue_ready_o, 0);
      chk({nm, "_ex_sel"},   bif.ex_circuit_sel_o, v.sel);
      chk({nm, "_ex_dst"},   bif.ex_destination_o, v.d);
      chk({nm, "_ex_wben"},  bif.wb_en_o, 0);
      chk({nm, "_ex_psw"},   bif.psw_we_o, 0);
    end
    @(negedge clk); #1;
    chk({nm, "_wb1_en"},  bif.wb_en_o, v.wb1);
    chk({nm, "_wb1_psw"}, bif.psw_we_o, v.psw);
    chk({nm, "_wb1_rdy"}, bif.issue_ready_o, 0);
    if (v.wb1) begin
      chk({nm, "_wb1_addr"}, bif.wb_addr_o, v.d);
      chk({nm, "_wb1_data"}, bif.wb_data_o, v.r);
    end
    if (v.dual) begin
      @(negedge clk); #1;
      chk({nm, "_wb2_en"},  bif.wb_en_o, v.wb2);
      chk({nm, "_wb2_psw"}, bif.psw_we_o, 0);
      chk({nm, "_wb2_rdy"}, bif.issue_ready_o, 0);
      if (v.wb2) begin
        chk({nm, "_wb2_addr"}, bif.wb_addr_o, v.d2);
        chk({nm, "_wb2_data"}, bif.wb_data_o, v.r2);
      end
    end
    @(negedge clk); #1;
    chk_idle({nm, "_done"});
  endtask

  vec_t tbl[$];

  initial begin
    // random model state
    bit          m_act;
    int          m_start, rel, n;
    logic [9:0]  m_sel;
    logic [4:0]  m_d, m_d2;
    cls_t        m_c;
    logic [9:0]  picks[12];
    bit          v, fl;
    logic [9:0]  s;

    rst = 1'b1;
    drive(0, 10'h0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); @(negedge clk); #1;
    chk_idle("reset");
    chk("reset_dst",  bif.ex_destination_o, 0);
    chk("reset_dst2", bif.ex_destination2_o, 0);
    chk("reset_addr", bif.wb_addr_o, 0);
    chk("reset_data", bif.wb_data_o, 0);
    rst = 1'b0;

    //           sel     d   d2  r             r2            lat dual wb1 psw wb2
    tbl.push_back('{10'h020, 5,  0, 32'h7,        32'h0,        1,  0,  1,  1,  0}); // ADD
    tbl.push_back('{10'h080, 3,  4, 32'h1,        32'hFFFF_FFFF, 2, 1,  1,  0,  1}); // MUL
    tbl.push_back('{10'h008, 9,  0, 32'h1234,     32'h55,       34, 1,  1,  1,  0}); // DIV, dest2=0
    tbl.push_back('{10'h000, 6,  0, 32'hA,        32'h0,        1,  0,  0,  1,  0}); // CMP
    tbl.push_back('{10'h040, 6,  0, 32'hB,        32'h0,        1,  0,  0,  1,  0}); // SAR
    tbl.push_back('{10'h021, 0,  0, 32'hC,        32'h0,        1,  0,  0,  0,  0}); // MOV to r0
    tbl.push_back('{10'h021, 7,  0, 32'hD,        32'h0,        1,  0,  1,  0,  0}); // MOV
    tbl.push_back('{10'h022, 12, 0, 32'hE,        32'h0,        1,  0,  1,  1,  0}); // ADD family
    tbl.push_back('{10'h002, 1,  0, 32'hF0,       32'h0,        1,  0,  1,  1,  0}); // AND
    tbl.push_back('{10'h003, 2,  0, 32'hF1,       32'h0,        1,  0,  1,  1,  0}); // OR
    tbl.push_back('{10'h006, 8,  0, 32'hF2,       32'h0,        1,  0,  1,  1,  0}); // BSH
    tbl.push_back('{10'h007, 11, 0, 32'hF3,       32'h0,        1,  0,  1,  1,  0}); // BSW
    tbl.push_back('{10'h010, 13, 0, 32'hF4,       32'h0,        1,  0,  1,  1,  0}); // HSH
    tbl.push_back('{10'h004, 14, 0, 32'hF5,       32'h0,        1,  0,  0,  0,  0}); // unknown -> NOP
    tbl.push_back('{10'h100, 15, 0, 32'hF6,       32'h0,        1,  0,  0,  0,  0}); // unknown -> NOP
    tbl.push_back('{10'h080, 10, 10, 32'hAA,      32'hBB,       2,  1,  1,  0,  1}); // MUL dest2==dest
    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

    // Flush at EXEC cycle 10 of a DIV: no commit, IDLE next cycle.
    @(negedge clk); drive(1, 10'h008, 9, 1, 0, 32'h99, 32'h98); #1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); bif.issue_valid_i = 0; bif.flush_i = (i == 10); #1;
      chk("dflush_exec_busy", bif.busy_o, 1);
      chk("dflush_exec_wben", bif.wb_en_o, 0);
      chk("dflush_exec_psw",  bif.psw_we_o, 0);
    end
    @(negedge clk); bif.flush_i = 0; #1;
    chk_idle("dflush_after");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      chk("dflush_quiet_wben", bif.wb_en_o, 0);
      chk("dflush_quiet_psw",  bif.psw_we_o, 0);
    end

    // Flush during MUL WB1: WB2 still happens.
    @(negedge clk); drive(1, 10'h080, 3, 4, 0, 32'h1, 32'hFFFF_FFFF); #1;
    @(negedge clk); bif.issue_valid_i = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); bif.flush_i = 1; #1;
    chk("mflush_wb1_en",   bif.wb_en_o, 1);
    chk("mflush_wb1_addr", bif.wb_addr_o, 3);
    @(negedge clk); bif.flush_i = 0; #1;
    chk("mflush_wb2_en",   bif.wb_en_o, 1);
    chk("mflush_wb2_addr", bif.wb_addr_o, 4);
    chk("mflush_wb2_data", bif.wb_data_o, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    chk_idle("mflush_done");

    // Flush while idle does not block a same-cycle issue.
    @(negedge clk); drive(1, 10'h020, 5, 0, 1, 32'h77, 32'h0); #1;
    @(negedge clk); drive(0, 10'h020, 5, 0, 0, 32'h77, 32'h0); #1;
    chk("iflush_busy", bif.busy_o, 1);
    chk("iflush_sel",  bif.ex_circuit_sel_o, 10'h020);
    @(negedge clk); #1;
    chk("iflush_wben", bif.wb_en_o, 1);
    chk("iflush_data", bif.wb_data_o, 32'h77);
    @(negedge clk); #1;

    // Reset in the middle of a DIV.
    @(negedge clk); drive(1, 10'h008, 9, 1, 0, 32'h5, 32'h6); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bif.issue_valid_i = 0; #1;
    end
    @(negedge clk); rst = 1; #1;
    @(negedge clk); rst = 0; #1;
    chk_idle("mrst");
    chk("mrst_dst",  bif.ex_destination_o, 0);
    chk("mrst_dst2", bif.ex_destination2_o, 0);
    chk("mrst_addr", bif.wb_addr_o, 0);
    chk("mrst_data", bif.wb_data_o, 0);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk); #1;
      chk("mrst_quiet_wben", bif.wb_en_o, 0);
      chk("mrst_quiet_psw",  bif.psw_we_o, 0);
    end
    run_op('{10'h100, 4, 0, 32'h1, 32'h0, 1, 0, 0, 0, 0}, "mrst_nop");

    // Random traffic vs. a per-op timeline: op accepted in period p occupies
    // EXEC periods p+1..p+lat, WB1 at p+lat+1, WB2 at p+lat+2 if dual.
    picks = '{10'h020, 10'h021, 10'h000, 10'h002, 10'h003, 10'h006,
              10'h008, 10'h010, 10'h040, 10'h080, 10'h100, 10'h000};
    m_act = 0; m_start = 0; m_sel = '0; m_d = '0; m_d2 = '0; m_c = classify(10'h0);
    for (n = 0; n < 1500; n++) begin
      @(negedge clk);
      v  = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 24) == 0);
      s  = picks[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) s = 10'($urandom);
      drive(v, s, 5'($urandom), 5'($urandom), fl, $urandom, $urandom);
      #1;
      rel = n - m_start;
      if (!m_act) begin
        chk_idle("rnd_idle");
      end else if (rel <= m_c.lat) begin
        chk("rnd_ex_ready", bif.issue_ready_o, 0);
        chk("rnd_ex_sel",   bif.ex_circuit_sel_o, m_sel);
        chk("rnd_ex_wben",  bif.wb_en_o, 0);
        chk("rnd_ex_psw",   bif.psw_we_o, 0);
      end else if (rel == m_c.lat + 1) begin
        chk("rnd_wb1_en",  bif.wb_en_o, m_c.gr && (m_d != 0));
        chk("rnd_wb1_psw", bif.psw_we_o, m_c.psw);
        chk("rnd_wb1_sel", bif.ex_circuit_sel_o, m_sel);
        if (m_c.gr && m_d != 0) begin
          chk("rnd_wb1_addr", bif.wb_addr_o, m_d);
          chk("rnd_wb1_data", bif.wb_data_o, bif.result_i);
        end
      end else begin
        chk("rnd_wb2_en",  bif.wb_en_o, m_d2 != 0);
        chk("rnd_wb2_psw", bif.psw_we_o, 0);
        if (m_d2 != 0) begin
          chk("rnd_wb2_addr", bif.wb_addr_o, m_d2);
          chk("rnd_wb2_data", bif.wb_data_o, bif.result2_i);
        end
      end
      // advance the model to the next period
      if (m_act) begin
        if (rel <= m_c.lat && fl)                    m_act = 0;
        else if (rel == m_c.lat + 1 && !m_c.dual)    m_act = 0;
        else if (rel == m_c.lat + 2)                 m_act = 0;
      end else if (v) begin
        m_act = 1; m_start = n; m_sel = s;
        m_d = bif.destination_i; m_d2 = bif.destination2_i;
        m_c = classify(s);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_issue_seq.md
Name: ex_issue_seq

Overview:
- Issue/writeback sequencer for the execute-stage ALU (the `circuit_sel` datapath with single and dual results).
- Accepts one decoded op at a time from decode via valid/ready and holds the op code and destination numbers stable on the ALU for the op-class latency.
- Commits the result(s) to the general-register file through its single write port, plus a PSW write enable.
- Serialises dual-result ops (MUL, DIV) into two write-back cycles and stalls decode while busy.

Parameters:
- ALU_LAT, 1, cycles from op launch to valid `result` for single-cycle classes (ADD/MOV/CMP/AND/OR/BSH/BSW/HSH/HSW/SAR).
- MUL_LAT, 2, cycles for MUL/MULH (two-cycle multicycle path).
- DIV_LAT, 34, cycles for DIV (multicycle path budget).
- NOP_SEL, 10'h200, `circuit_sel` code driven when idle; matches no ALU function.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid_i  in  1  decode presents an op
- issue_ready_o  out  1  sequencer accepts an op this cycle
- circuit_sel_i  in  10  op code from decode
- destination_i  in  5  primary destination register number
- destination2_i  in  5  secondary destination register number (MUL/DIV)
- flush_i  in  1  abort in-flight op (branch redirect)
- ex_circuit_sel_o  out  10  op code to ALU
- ex_destination_o  out  5  destination to ALU
- ex_destination2_o  out  5  destination2 to ALU
- result_i  in  32  ALU primary result
- result2_i  in  32  ALU secondary result
- wb_en_o  out  1  GR write enable
- wb_addr_o  out  5  GR write address
- wb_data_o  out  32  GR write data
- psw_we_o  out  1  commit ALU PSW flags this cycle
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (`rst`=1 at posedge), which applies in any state and may occur mid-operation:
  - State returns to IDLE and the counter is cleared.
  - `ex_circuit_sel_o` = NOP_SEL; `ex_destination_o` and `ex_destination2_o` = 0.
  - `wb_en_o`, `psw_we_o` and `busy_o` = 0; `wb_addr_o` and `wb_data_o` = 0.
  - No write issued for an aborted op.
- `issue_ready_o` = (state==IDLE). An op is accepted at a posedge with `issue_valid_i` & `issue_ready_o`.
- Op class decode from `circuit_sel_i`, evaluated in priority order:
  - bit5=1 & bit0=1: MOV; 1 result; no PSW.
  - bit5=1 & bit0=0: ADD family; 1 result; PSW.
  - ==0: CMP; no GR write; PSW.
  - ==2: AND; 1 result; PSW.
  - ==3: OR; 1 result; PSW.
  - [4:1]==4'b0011: BSH/BSW; 1 result; PSW.
  - ==8: DIV; 2 results; PSW; latency DIV_LAT.
  - ==16: HSH/HSW; 1 result; PSW.
  - ==64: SAR; no GR write; PSW.
  - ==128: MUL; 2 results; no PSW; latency MUL_LAT.
  - Anything else: NOP; no writes; latency 1.
  - All classes other than DIV and MUL use latency ALU_LAT.
- Launch: on accept, the `ex_*` outputs register the op and hold it until return to IDLE. The counter loads LAT-1 and the state goes to EXEC.
- EXEC:
  - The counter decrements each cycle.
  - When the counter==0 and `flush_i`=0, go to WB1.
  - `flush_i`=1 in EXEC returns to IDLE with no writes and drives NOP_SEL next cycle.
- WB1 (1 cycle):
  - `wb_en_o`=1 iff the class writes GR and `destination` != 0; `wb_addr_o` = `destination`; `wb_data_o` = `result_i`.
  - `psw_we_o`=1 iff the class sets PSW.
  - Next state is WB2 if the class is dual-result, else IDLE.
- WB2 (1 cycle):
  - `wb_en_o`=1 iff `destination2` != 0; `wb_addr_o` = `destination2`; `wb_data_o` = `result2_i`; `psw_we_o`=0.
  - When `destination2` == `destination`, the WB2 write lands last and wins.
- `flush_i` in WB1/WB2 is ignored: commit completes.
- `flush_i` in IDLE: the op is still accepted if presented the same cycle. Flush is decode's responsibility there.
- On entering IDLE, `ex_circuit_sel_o` returns to NOP_SEL.
- Occupancy per op: 1-result op = LAT+1 cycles; 2-result op = LAT+2 cycles. Back-to-back issue is accepted on the first IDLE cycle.
- Write-back outputs are combinational from state and registered destinations. All other outputs are registered.

Test Plan:
- ADD: `circuit_sel`=0x020, dest=5, `result_i`=0x0000_0007 → exactly one cycle `wb_en_o`=1, addr 5, data 7, `psw_we_o`=1; `issue_ready_o` low for 2 cycles.
- MUL: 0x080, dest=3, dest2=4, `result`=0x1, `result2`=0xFFFF_FFFF → WB1 addr 3 data 1, then WB2 addr 4 data 0xFFFF_FFFF; `psw_we_o`=0 throughout; accept-to-WB1 = 2 cycles.
- DIV: 0x008, dest2=0 → WB1 after 34 EXEC cycles with `psw_we_o`=1; WB2 asserts no write.
- CMP 0x000 and SAR 0x040 → `psw_we_o`=1, `wb_en_o`=0. MOV 0x021 to dest 0 → no GR write and no PSW write.
- Flush during DIV EXEC at cycle 10 → no `wb_en_o` or `psw_we_o`, IDLE next cycle, `ex_circuit_sel_o`=0x200. Flush asserted during MUL WB1 → WB2 still occurs.
- Reset asserted mid-DIV → next cycle all outputs at reset values; the following issue is accepted normally and unknown code 0x100 completes as a 1-cycle NOP with no writes.
